r_resp_arbiter: RTL and testbench
=================================

// Module: r_resp_arbiter
// PURPOSE
//   Per-master read-response arbiter on the AXI R channel, directly downstream of the slave-side ID
//   decoders. Each slave's decoder raises a request toward this master; this block picks one slave
//   and locks it for a whole burst until the RLAST handshake. It muxes that slave's R payload to the
//   master and drives RREADY back only to the granted slave. One instance per master.
// PARAMETERS
//   NUM_S    4   number of slave R ports, including the default slave (index NUM_S-1)
//   DATA_W   32  RDATA width
//   IDM_W    4   master-side ID width; slave-side ID width = IDM_W+4
// PORTS
//   ACLK      in   1                clock
//   ARESETn   in   1                async active-low reset
//   req_i     in   NUM_S            per-slave request for this master (from slave-side ID decoders)
//   RID_S     in   NUM_S*(IDM_W+4)  slave RIDs, flattened, slave 0 in LSBs
//   RDATA_S   in   NUM_S*DATA_W     slave RDATA, flattened
//   RRESP_S   in   NUM_S*2          slave RRESP, flattened
//   RLAST_S   in   NUM_S            slave RLAST
//   RVALID_S  in   NUM_S            slave RVALID
//   RREADY_S  out  NUM_S            RREADY to each slave's decoder (this master's input)
//   RID_M     out  IDM_W            master RID = low IDM_W bits of the granted slave's RID
//   RDATA_M   out  DATA_W           master RDATA
//   RRESP_M   out  2                master RRESP
//   RLAST_M   out  1                master RLAST
//   RVALID_M  out  1                master RVALID
//   RREADY_M  in   1                master RREADY
//   busy_o    out  1                burst lock held
//   beat_o    out  8                beats accepted in the current burst (debug)
// BEHAVIOUR
//   - Reset (async, ARESETn=0): state IDLE, grant=0, rr_ptr=0, beat_o=0. While in IDLE: RVALID_M=0,
//     RREADY_S=0, RID_M/RDATA_M/RRESP_M/RLAST_M=0.
//   - Eligible slave i: req_i[i] & RVALID_S[i].
//   - IDLE: if any slave is eligible, load grant with a one-hot pick starting the round-robin search
//     at rr_ptr (rr_ptr, rr_ptr+1, ... mod NUM_S), then go to LOCK. Latency: 1 cycle from RVALID_S to RVALID_M.
//   - LOCK: outputs are a combinational mux of the granted slave.
//     RVALID_M = RVALID_S[g]. RREADY_S[g] = RREADY_M. All other RREADY_S bits = 0.
//     A beat is accepted when RVALID_M & RREADY_M; on each beat, beat_o increments (saturates at 255).
//   - Burst end: a beat with RLAST_S[g]=1 sends the block to IDLE next cycle. On that edge rr_ptr =
//     (g+1) mod NUM_S and beat_o clears to 0. IDLE always costs one bubble cycle between bursts.
//   - Grant is held for the whole burst. It ignores req_i/RVALID gaps from the granted slave
//     (RVALID_M drops, lock stays). Other slaves' requests wait, and the AXI rule says they hold RVALID.
//   - Simultaneous requests: round-robin order only, with no fixed priority. A slave granted in one
//     burst ranks last in the next arbitration.
//   - req_i[i] with RVALID_S[i]=0 is not eligible. Grant is decided only from eligible slaves.
//   - Reset mid-burst: the block drops to IDLE immediately and the burst is abandoned with no further
//     RREADY_S. Slave recovery is the slave's own reset.
//   - No combinational path from RREADY_M to RVALID_M.
// STRUCTURE
//   - Shared package axi_pkg: DATA_W, IDM_W and IDS_W constants; RRESP codes OKAY=2'b00,
//     DECERR=2'b11; r_arb_state_e {IDLE, LOCK}.
//   - Sub-module rr_pick: combinational round-robin picker, NUM_S-bit request plus pointer in,
//     one-hot grant and valid out.
//   - Top-level: state FSM, grant/rr_ptr/beat registers, payload mux, RREADY_S fan-out.
// TESTING
//   1 Reset: assert ARESETn=0 with RVALID_S=4'b1111 and req_i=4'b1111 -> RVALID_M=0, RREADY_S=0, busy_o=0.
//   2 Single burst: slave1 presents RID=8'h25, 4 beats with RDATA 0xA0..0xA3, RREADY_M=1 ->
//     RVALID_M rises 1 cycle later, RID_M=4'h5, data in order, RLAST_M on beat 4, beat_o reaches 3 then clears.
//   3 Contention: slaves 0 and 2 request in the same cycle with rr_ptr=0 -> slave0 is served first;
//     slave2 is served after one bubble cycle; RREADY_S[2]=0 throughout slave0's burst.
//   4 Fairness: slaves 0 and 1 request continuously for 6 bursts -> grants alternate 0,1,0,1,0,1.
//   5 Backpressure and gaps: RREADY_M toggles and the granted slave drops RVALID for 2 cycles mid-burst
//     -> no beat lost or duplicated, lock held, beat_o counts only handshakes.
//   6 Reset mid-burst: ARESETn=0 at beat 2 of 4 -> RVALID_M and RREADY_S go 0 immediately; after
//     release, the block is IDLE with rr_ptr=0.

Source files
------------

// File: rtl/r_resp_arbiter_pkg.sv
// Shared constants and types for the per-master R-channel response arbiter.
package r_resp_arbiter_pkg;

  localparam int unsigned NUM_S  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned IDM_W  = 4;
  localparam int unsigned IDS_W  = IDM_W + 4;

  localparam logic [1:0] RRESP_OKAY   = 2'b00;
  localparam logic [1:0] RRESP_DECERR = 2'b11;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } r_arb_state_e;

endpackage

// File: rtl/r_resp_arbiter_if.sv
// R-channel bundle between the slave-side decoders, the arbiter and one master.
interface r_resp_arbiter_if #(
  parameter int unsigned NUM_S  = r_resp_arbiter_pkg::NUM_S,
  parameter int unsigned DATA_W = r_resp_arbiter_pkg::DATA_W,
  parameter int unsigned IDM_W  = r_resp_arbiter_pkg::IDM_W
);
  localparam int unsigned IDS_W = IDM_W + 4;

  logic [NUM_S-1:0]        req_i;
  logic [NUM_S*IDS_W-1:0]  RID_S;
  logic [NUM_S*DATA_W-1:0] RDATA_S;
  logic [NUM_S*2-1:0]      RRESP_S;
  logic [NUM_S-1:0]        RLAST_S;
  logic [NUM_S-1:0]        RVALID_S;
  logic [NUM_S-1:0]        RREADY_S;
  logic [IDM_W-1:0]        RID_M;
  logic [DATA_W-1:0]       RDATA_M;
  logic [1:0]              RRESP_M;
  logic                    RLAST_M;
  logic                    RVALID_M;
  logic                    RREADY_M;
  logic                    busy_o;
  logic [7:0]              beat_o;

  // Environment side: slaves plus the master's ready.
  modport master (
    output req_i, RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S, RREADY_M,
    input  RREADY_S, RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M, busy_o, beat_o
  );

  // Arbiter side.
  modport slave (
    input  req_i, RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S, RREADY_M,
    output RREADY_S, RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M, busy_o, beat_o
  );

endinterface

// File: rtl/r_resp_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module r_resp_arbiter_rr_pick #(
  parameter int unsigned NUM_S = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [NUM_S-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NUM_S-1:0] gnt_c,
  output logic             valid_c
);

  logic [PTR_W-1:0] idx;

  // Scan ptr, ptr+1, ... mod NUM_S and take the first requester.
  always_comb begin
    gnt_c   = '0;
    valid_c = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < NUM_S; k++) begin
      idx = PTR_W'((32'(ptr) + k) % NUM_S);
      if (!valid_c && req[idx]) begin
        gnt_c[idx] = 1'b1;
        valid_c    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/r_resp_arbiter.sv
// Per-master R-channel arbiter: locks one slave for a whole burst, muxes its payload.
module r_resp_arbiter #(
  parameter int unsigned NUM_S  = r_resp_arbiter_pkg::NUM_S,
  parameter int unsigned DATA_W = r_resp_arbiter_pkg::DATA_W,
  parameter int unsigned IDM_W  = r_resp_arbiter_pkg::IDM_W
) (
  input logic             ACLK,
  input logic             ARESETn,
  r_resp_arbiter_if.slave bus
);
  localparam int unsigned IDS_W = IDM_W + 4;
  localparam int unsigned PTR_W = (NUM_S > 1) ? $clog2(NUM_S) : 1;

  import r_resp_arbiter_pkg::*;

  r_arb_state_e      state_q, state_d;
  logic [NUM_S-1:0]  grant_q, grant_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [7:0]        beat_q, beat_d;

  logic [NUM_S-1:0]  elig;
  logic [NUM_S-1:0]  pick_gnt;
  logic              pick_vld;
  logic [PTR_W-1:0]  g_idx;
  logic              lock;
  logic              beat_hs;
  logic              beat_last;

  logic [IDM_W-1:0]  sel_id;
  logic [DATA_W-1:0] sel_data;
  logic [1:0]        sel_resp;
  logic              sel_last;
  logic              sel_valid;

  // Upper (slave-tag) RID bits are dropped on the way to the master.
  logic              unused_rid;
  assign unused_rid = ^bus.RID_S;

  assign elig = bus.req_i & bus.RVALID_S;

  r_resp_arbiter_rr_pick #(
    .NUM_S (NUM_S),
    .PTR_W (PTR_W)
  ) u_pick (
    .req     (elig),
    .ptr     (rr_ptr_q),
    .gnt_c   (pick_gnt),
    .valid_c (pick_vld)
  );

  // Select the granted slave's payload and index from the one-hot grant.
  always_comb begin
    sel_id    = '0;
    sel_data  = '0;
    sel_resp  = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    g_idx     = '0;
    for (int unsigned s = 0; s < NUM_S; s++) begin
      if (grant_q[s]) begin
        g_idx     = PTR_W'(s);
        sel_id    = bus.RID_S[s*IDS_W +: IDM_W];
        sel_data  = bus.RDATA_S[s*DATA_W +: DATA_W];
        sel_resp  = bus.RRESP_S[s*2 +: 2];
        sel_last  = bus.RLAST_S[s];
        sel_valid = bus.RVALID_S[s];
      end
    end
  end

  assign lock      = (state_q == LOCK);
  assign beat_hs   = lock & sel_valid & bus.RREADY_M;
  assign beat_last = beat_hs & sel_last;

  assign bus.RVALID_M = lock & sel_valid;
  assign bus.RID_M    = lock ? sel_id   : '0;
  assign bus.RDATA_M  = lock ? sel_data : '0;
  assign bus.RRESP_M  = lock ? sel_resp : '0;
  assign bus.RLAST_M  = lock & sel_last;
  assign bus.RREADY_S = lock ? (grant_q & {NUM_S{bus.RREADY_M}}) : '0;
  assign bus.busy_o   = lock;
  assign bus.beat_o   = beat_q;

  // Next-state: grab an eligible slave in IDLE, release after the RLAST handshake.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    beat_d   = beat_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = LOCK;
          grant_d = pick_gnt;
        end
      end
      LOCK: begin
        if (beat_hs && (beat_q != 8'hFF)) begin
          beat_d = beat_q + 8'd1;
        end
        if (beat_last) begin
          state_d  = IDLE;
          grant_d  = '0;
          beat_d   = '0;
          rr_ptr_d = (g_idx == PTR_W'(NUM_S - 1)) ? '0 : g_idx + PTR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State, grant, round-robin pointer and beat counter registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      beat_q   <= beat_d;
    end
  end

endmodule

// File: tb/tb_r_resp_arbiter.sv
// Directed bench for the per-master R-channel response arbiter.
module tb_r_resp_arbiter;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  r_resp_arbiter_if bus ();

  r_resp_arbiter dut (
    .ACLK    (clk),
    .ARESETn (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clr();
    bus.req_i    = '0;
    bus.RVALID_S = '0;
    bus.RLAST_S  = '0;
    bus.RID_S    = '0;
    bus.RDATA_S  = '0;
    bus.RRESP_S  = '0;
  endtask

  task automatic set_s(input int unsigned s, input logic v, input logic l,
                       input logic [7:0] id, input logic [31:0] d, input logic [1:0] r);
    bus.req_i[s]          = v;
    bus.RVALID_S[s]       = v;
    bus.RLAST_S[s]        = l;
    bus.RID_S[s*8 +: 8]   = id;
    bus.RDATA_S[s*32 +: 32] = d;
    bus.RRESP_S[s*2 +: 2] = r;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.RREADY_M = 1'b1;
    bus.req_i    = 4'b1111;
    bus.RVALID_S = 4'b1111;
    bus.RLAST_S  = 4'b1111;
    bus.RID_S    = 32'hFFFF_FFFF;
    bus.RDATA_S  = {4{32'hDEAD_BEEF}};
    bus.RRESP_S  = 8'hFF;
    repeat (2) adv();
    mid();
    n_cmp++;
    if ({bus.RVALID_M, bus.RREADY_S, bus.busy_o} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 000000", {bus.RVALID_M, bus.RREADY_S, bus.busy_o});
    end
    n_cmp++;
    if (bus.beat_o !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_beat: got %h want 00", bus.beat_o);
    end
    n_cmp++;
    if ({bus.RID_M, bus.RDATA_M, bus.RRESP_M, bus.RLAST_M} !== 39'd0) begin
      n_bad++;
      $display("FAIL reset_payload: got %h want 0", {bus.RID_M, bus.RDATA_M, bus.RRESP_M, bus.RLAST_M});
    end
    clr();
    bus.RREADY_M = 1'b0;
    adv();
    rst_n = 1'b1;
    mid();
    n_cmp++;
    if (bus.busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release_busy: got %b want 0", bus.busy_o);
    end
    adv();
  endtask

  task automatic test_single_burst();
    bus.RREADY_M = 1'b1;
    set_s(1, 1'b1, 1'b0, 8'h25, 32'hA0, 2'b00);
    mid();
    n_cmp++;
    if (bus.RVALID_M !== 1'b0) begin
      n_bad++;
      $display("FAIL single_latency: got %b want 0", bus.RVALID_M);
    end
    adv();
    for (int k = 0; k < 4; k++) begin
      set_s(1, 1'b1, (k == 3), 8'h25, 32'hA0 + 32'(k), 2'b00);
      mid();
      n_cmp++;
      if ({bus.RVALID_M, bus.RLAST_M} !== {1'b1, (k == 3)}) begin
        n_bad++;
        $display("FAIL single_valid_last beat %0d: got %b want %b", k, {bus.RVALID_M, bus.RLAST_M}, {1'b1, (k == 3)});
      end
      n_cmp++;
      if ({bus.RID_M, bus.RDATA_M} !== {4'h5, 32'hA0 + 32'(k)}) begin
        n_bad++;
        $display("FAIL single_id_data beat %0d: got %h want %h", k, {bus.RID_M, bus.RDATA_M}, {4'h5, 32'hA0 + 32'(k)});
      end
      n_cmp++;
      if ({bus.RREADY_S, bus.beat_o} !== {4'b0010, 8'(k)}) begin
        n_bad++;
        $display("FAIL single_ready_beat beat %0d: got %h want %h", k, {bus.RREADY_S, bus.beat_o}, {4'b0010, 8'(k)});
      end
      adv();
    end
    clr();
    mid();
    n_cmp++;
    if ({bus.busy_o, bus.beat_o, bus.RVALID_M} !== 10'd0) begin
      n_bad++;
      $display("FAIL single_end: got %h want 000", {bus.busy_o, bus.beat_o, bus.RVALID_M});
    end
    adv();
  endtask

  task automatic test_contention();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    adv();
    bus.RREADY_M = 1'b1;
    set_s(0, 1'b1, 1'b0, 8'h01, 32'h0, 2'b00);
    set_s(2, 1'b1, 1'b0, 8'h2E, 32'hC0, 2'b00);
    mid();
    n_cmp++;
    if (bus.RVALID_M !== 1'b0) begin
      n_bad++;
      $display("FAIL cont_latency: got %b want 0", bus.RVALID_M);
    end
    adv();
    for (int k = 0; k < 2; k++) begin
      set_s(0, 1'b1, (k == 1), 8'h01, 32'(k), 2'b00);
      mid();
      n_cmp++;
      if ({bus.RREADY_S, bus.RDATA_M} !== {4'b0001, 32'(k)}) begin
        n_bad++;
        $display("FAIL cont_s0 beat %0d: got %h want %h", k, {bus.RREADY_S, bus.RDATA_M}, {4'b0001, 32'(k)});
      end
      adv();
    end
    set_s(0, 1'b0, 1'b0, 8'h00, 32'h0, 2'b00);
    mid();
    n_cmp++;
    if ({bus.RVALID_M, bus.busy_o, bus.RREADY_S} !== 6'b0) begin
      n_bad++;
      $display("FAIL cont_bubble: got %b want 000000", {bus.RVALID_M, bus.busy_o, bus.RREADY_S});
    end
    adv();
    for (int k = 0; k < 2; k++) begin
      set_s(2, 1'b1, (k == 1), 8'h2E, 32'hC0 + 32'(k), 2'b00);
      mid();
      n_cmp++;
      if ({bus.RREADY_S, bus.RID_M, bus.RDATA_M} !== {4'b0100, 4'hE, 32'hC0 + 32'(k)}) begin
        n_bad++;
        $display("FAIL cont_s2 beat %0d: got %h want %h", k, {bus.RREADY_S, bus.RID_M, bus.RDATA_M},
                 {4'b0100, 4'hE, 32'hC0 + 32'(k)});
      end
      adv();
    end
    clr();
    mid();
    n_cmp++;
    if (bus.busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL cont_end: got %b want 0", bus.busy_o);
    end
    adv();
  endtask

  task automatic test_fairness();
    int exp;
    bus.RREADY_M = 1'b1;
    set_s(0, 1'b1, 1'b1, 8'h10, 32'hB0, 2'b00);
    set_s(1, 1'b1, 1'b1, 8'h11, 32'hB1, 2'b00);
    for (int b = 0; b < 6; b++) begin
      exp = b % 2;
      mid();
      n_cmp++;
      if (bus.busy_o !== 1'b0) begin
        n_bad++;
        $display("FAIL fair_bubble burst %0d: got %b want 0", b, bus.busy_o);
      end
      adv();
      mid();
      n_cmp++;
      if ({bus.RREADY_S, bus.RDATA_M} !== {4'b0001 << exp, 32'hB0 + 32'(exp)}) begin
        n_bad++;
        $display("FAIL fair_grant burst %0d: got %h want %h", b, {bus.RREADY_S, bus.RDATA_M},
                 {4'b0001 << exp, 32'hB0 + 32'(exp)});
      end
      adv();
    end
    clr();
    adv();
  endtask

  task automatic test_backpressure_gaps();
    logic       tv_v [8];
    logic       tv_r [8];
    logic       tv_q [8];
    logic       tv_l [8];
    logic [1:0] tv_d [8];
    logic [7:0] ex_beat [8];
    tv_v    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    tv_r    = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tv_q    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    tv_l    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tv_d    = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2};
    ex_beat = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2};
    bus.RREADY_M = 1'b0;
    set_s(3, 1'b1, 1'b0, 8'h3C, 32'hD0, 2'b11);
    mid();
    n_cmp++;
    if (bus.RVALID_M !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_latency: got %b want 0", bus.RVALID_M);
    end
    adv();
    for (int c = 0; c < 8; c++) begin
      set_s(3, tv_v[c], tv_l[c], 8'h3C, 32'hD0 + 32'(tv_d[c]), 2'b11);
      bus.req_i[3] = tv_q[c];
      bus.RREADY_M = tv_r[c];
      mid();
      n_cmp++;
      if ({bus.RVALID_M, bus.busy_o, bus.RREADY_S} !== {tv_v[c], 1'b1, (tv_r[c] ? 4'b1000 : 4'b0000)}) begin
        n_bad++;
        $display("FAIL bp_ctrl cycle %0d: got %b want %b", c, {bus.RVALID_M, bus.busy_o, bus.RREADY_S},
                 {tv_v[c], 1'b1, (tv_r[c] ? 4'b1000 : 4'b0000)});
      end
      n_cmp++;
      if (bus.beat_o !== ex_beat[c]) begin
        n_bad++;
        $display("FAIL bp_beat cycle %0d: got %0d want %0d", c, bus.beat_o, ex_beat[c]);
      end
      if (tv_v[c]) begin
        n_cmp++;
        if ({bus.RDATA_M, bus.RLAST_M, bus.RRESP_M, bus.RID_M} !== {32'hD0 + 32'(tv_d[c]), tv_l[c], 2'b11, 4'hC}) begin
          n_bad++;
          $display("FAIL bp_payload cycle %0d: got %h want %h", c, {bus.RDATA_M, bus.RLAST_M, bus.RRESP_M, bus.RID_M},
                   {32'hD0 + 32'(tv_d[c]), tv_l[c], 2'b11, 4'hC});
        end
      end
      adv();
    end
    clr();
    bus.RREADY_M = 1'b0;
    mid();
    n_cmp++;
    if ({bus.busy_o, bus.beat_o} !== 9'd0) begin
      n_bad++;
      $display("FAIL bp_end: got %h want 000", {bus.busy_o, bus.beat_o});
    end
    adv();
  endtask

  task automatic test_reset_mid();
    bus.RREADY_M = 1'b1;
    set_s(0, 1'b1, 1'b1, 8'h07, 32'hE0, 2'b00);
    mid();
    adv();
    mid();
    n_cmp++;
    if (bus.RREADY_S !== 4'b0001) begin
      n_bad++;
      $display("FAIL rm_pre_s0: got %b want 0001", bus.RREADY_S);
    end
    adv();
    clr();
    set_s(2, 1'b1, 1'b0, 8'h2A, 32'hF0, 2'b00);
    mid();
    adv();
    mid();
    n_cmp++;
    if ({bus.RREADY_S, bus.beat_o} !== {4'b0100, 8'd0}) begin
      n_bad++;
      $display("FAIL rm_beat1: got %h want 400", {bus.RREADY_S, bus.beat_o});
    end
    adv();
    set_s(2, 1'b1, 1'b0, 8'h2A, 32'hF1, 2'b00);
    mid();
    n_cmp++;
    if ({bus.RVALID_M, bus.beat_o} !== {1'b1, 8'd1}) begin
      n_bad++;
      $display("FAIL rm_beat2: got %h want 101", {bus.RVALID_M, bus.beat_o});
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.RVALID_M, bus.RREADY_S, bus.busy_o, bus.beat_o} !== 14'd0) begin
      n_bad++;
      $display("FAIL rm_async: got %h want 0000", {bus.RVALID_M, bus.RREADY_S, bus.busy_o, bus.beat_o});
    end
    #2;
    clr();
    rst_n = 1'b1;
    adv();
    set_s(0, 1'b1, 1'b1, 8'h07, 32'hE5, 2'b00);
    set_s(1, 1'b1, 1'b1, 8'h17, 32'hE6, 2'b00);
    mid();
    n_cmp++;
    if (bus.busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL rm_idle: got %b want 0", bus.busy_o);
    end
    adv();
    mid();
    n_cmp++;
    if ({bus.RREADY_S, bus.RDATA_M} !== {4'b0001, 32'hE5}) begin
      n_bad++;
      $display("FAIL rm_ptr_cleared: got %h want %h", {bus.RREADY_S, bus.RDATA_M}, {4'b0001, 32'hE5});
    end
    adv();
    clr();
    adv();
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.RREADY_M = 1'b0;
    clr();
    test_reset();
    test_single_burst();
    test_contention();
    test_fairness();
    test_backpressure_gaps();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
